// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with stall, flush and per-entry valid/illegal tracking.
// Define ID_EX_BUBBLE_CNT_EN to build the saturating bubble counter; otherwise bubble_cnt is tied to 0.
module id_ex_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             valid_d,
    input  logic [6:0]       op_d,
    input  logic             reg_write_d,
    input  logic             mem_write_d,
    input  logic             jump_d,
    input  logic             branch_d,
    input  logic             alu_src_a_d,
    input  logic             alu_src_b_d,
    input  logic             adder_src_d,
    input  logic [1:0]       res_src_d,
    input  logic [3:0]       alu_control_d,
    input  logic [2:0]       funct3_d,
    input  logic [XLEN-1:0]  rd1_d,
    input  logic [XLEN-1:0]  rd2_d,
    input  logic [XLEN-1:0]  imm_ext_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,

    input  logic             stall_e,
    input  logic             flush_e,

    output logic             valid_e,
    output logic             illegal_e,
    output logic [6:0]       op_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             jump_e,
    output logic             branch_e,
    output logic             alu_src_a_e,
    output logic             alu_src_b_e,
    output logic             adder_src_e,
    output logic [1:0]       res_src_e,
    output logic [3:0]       alu_control_e,
    output logic [2:0]       funct3_e,
    output logic [XLEN-1:0]  rd1_e,
    output logic [XLEN-1:0]  rd2_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [4:0]       rd_e,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic op_legal;
    logic live_d;

    always_comb begin
        case (op_d)
            OP_LOAD, OP_OP_IMM, OP_AUIPC, OP_STORE, OP_OP,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // A slot is live only if it is both occupied and decodable; otherwise it enters as a bubble.
    assign live_d = valid_d & op_legal;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_e   <= 1'b0;
            illegal_e <= 1'b0;
        end else if (flush_e) begin
            valid_e   <= 1'b0;
            illegal_e <= 1'b0;
        end else if (!stall_e) begin
            valid_e   <= live_d;
            illegal_e <= valid_d & ~op_legal;
        end
    end

    // Control gating is folded into the capture so bubbles leave the register already cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            adder_src_e   <= 1'b0;
            res_src_e     <= '0;
            alu_control_e <= '0;
            funct3_e      <= '0;
        end else if (flush_e || (!stall_e && !live_d)) begin
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            jump_e        <= 1'b0;
            branch_e      <= 1'b0;
            alu_src_a_e   <= 1'b0;
            alu_src_b_e   <= 1'b0;
            adder_src_e   <= 1'b0;
            res_src_e     <= '0;
            alu_control_e <= '0;
            funct3_e      <= '0;
        end else if (!stall_e) begin
            reg_write_e   <= reg_write_d;
            mem_write_e   <= mem_write_d;
            jump_e        <= jump_d;
            branch_e      <= branch_d;
            alu_src_a_e   <= alu_src_a_d;
            alu_src_b_e   <= alu_src_b_d;
            adder_src_e   <= adder_src_d;
            res_src_e     <= res_src_d;
            alu_control_e <= alu_control_d;
            funct3_e      <= funct3_d;
        end
    end

    // Data and indices are captured even for bubbles so an illegal instruction stays visible for debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_e       <= '0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
        end else if (flush_e) begin
            op_e       <= '0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_ext_e  <= '0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
        end else if (!stall_e) begin
            op_e       <= op_d;
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            imm_ext_e  <= imm_ext_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic bubble_evt;

    assign bubble_evt = flush_e | (~stall_e & ~live_d);

    // NOTE: only plain flops live here, so every one gets an asynchronous reset; the counter clears only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (bubble_evt && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg against a transaction-level reference model.
// Honours ID_EX_BUBBLE_CNT_EN the same way the design does.
module tb_id_ex_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [6:0] LEGAL_OPS [9] = '{
        7'b0000011, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
        7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111
    };

    typedef struct packed {
        logic            valid;
        logic [6:0]      op;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic            alu_src_a;
        logic            alu_src_b;
        logic            adder_src;
        logic [1:0]      res_src;
        logic [3:0]      alu_control;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } slot_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    slot_t di = '0;

    // Reference state: what the execute stage should be holding.
    slot_t exp_s = '0;
    logic  exp_illegal = 1'b0;
    int    exp_cnt = 0;

    int n_vec = 0;
    int n_err = 0;

    logic             valid_e, illegal_e;
    logic [6:0]       op_e;
    logic             reg_write_e, mem_write_e, jump_e, branch_e;
    logic             alu_src_a_e, alu_src_b_e, adder_src_e;
    logic [1:0]       res_src_e;
    logic [3:0]       alu_control_e;
    logic [2:0]       funct3_e;
    logic [XLEN-1:0]  rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
    logic [4:0]       rs1_e, rs2_e, rd_e;
    logic [CNT_W-1:0] bubble_cnt;

    id_ex_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_d(di.valid), .op_d(di.op),
        .reg_write_d(di.reg_write), .mem_write_d(di.mem_write),
        .jump_d(di.jump), .branch_d(di.branch),
        .alu_src_a_d(di.alu_src_a), .alu_src_b_d(di.alu_src_b), .adder_src_d(di.adder_src),
        .res_src_d(di.res_src), .alu_control_d(di.alu_control), .funct3_d(di.funct3),
        .rd1_d(di.rd1), .rd2_d(di.rd2), .imm_ext_d(di.imm),
        .pc_d(di.pc), .pc_plus4_d(di.pc4),
        .rs1_d(di.rs1), .rs2_d(di.rs2), .rd_d(di.rd),
        .stall_e(stall), .flush_e(flush),
        .valid_e(valid_e), .illegal_e(illegal_e), .op_e(op_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .jump_e(jump_e), .branch_e(branch_e),
        .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e), .adder_src_e(adder_src_e),
        .res_src_e(res_src_e), .alu_control_e(alu_control_e), .funct3_e(funct3_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
        .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] op);
        foreach (LEGAL_OPS[i]) if (LEGAL_OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_all(input string ctx);
        check({ctx, ".valid_e"},       32'(valid_e),       32'(exp_s.valid));
        check({ctx, ".illegal_e"},     32'(illegal_e),     32'(exp_illegal));
        check({ctx, ".op_e"},          32'(op_e),          32'(exp_s.op));
        check({ctx, ".reg_write_e"},   32'(reg_write_e),   32'(exp_s.reg_write));
        check({ctx, ".mem_write_e"},   32'(mem_write_e),   32'(exp_s.mem_write));
        check({ctx, ".jump_e"},        32'(jump_e),        32'(exp_s.jump));
        check({ctx, ".branch_e"},      32'(branch_e),      32'(exp_s.branch));
        check({ctx, ".alu_src_a_e"},   32'(alu_src_a_e),   32'(exp_s.alu_src_a));
        check({ctx, ".alu_src_b_e"},   32'(alu_src_b_e),   32'(exp_s.alu_src_b));
        check({ctx, ".adder_src_e"},   32'(adder_src_e),   32'(exp_s.adder_src));
        check({ctx, ".res_src_e"},     32'(res_src_e),     32'(exp_s.res_src));
        check({ctx, ".alu_control_e"}, 32'(alu_control_e), 32'(exp_s.alu_control));
        check({ctx, ".funct3_e"},      32'(funct3_e),      32'(exp_s.funct3));
        check({ctx, ".rd1_e"},         rd1_e,              exp_s.rd1);
        check({ctx, ".rd2_e"},         rd2_e,              exp_s.rd2);
        check({ctx, ".imm_ext_e"},     imm_ext_e,          exp_s.imm);
        check({ctx, ".pc_e"},          pc_e,               exp_s.pc);
        check({ctx, ".pc_plus4_e"},    pc_plus4_e,         exp_s.pc4);
        check({ctx, ".rs1_e"},         32'(rs1_e),         32'(exp_s.rs1));
        check({ctx, ".rs2_e"},         32'(rs2_e),         32'(exp_s.rs2));
        check({ctx, ".rd_e"},          32'(rd_e),          32'(exp_s.rd));
        check({ctx, ".bubble_cnt"},    32'(bubble_cnt),    32'(exp_cnt));
    endtask

    task automatic rand_inputs(input int p_flush, input int p_stall);
        logic [255:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
        di = slot_t'(r[$bits(slot_t)-1:0]);
        if ($urandom_range(0, 3) != 0) di.op = LEGAL_OPS[$urandom_range(0, 8)];
        di.valid = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 99) < p_flush);
        stall = ($urandom_range(0, 99) < p_stall);
    endtask

    // One clock: advance the reference from the inputs present at the edge, then compare.
    task automatic tick(input string ctx);
        bit live, bubble;
        @(posedge clk);
        live   = di.valid && is_legal(di.op);
        bubble = flush || (!stall && !live);
        if (flush) begin
            exp_s       = '0;
            exp_illegal = 1'b0;
        end else if (!stall) begin
            exp_s = di;
            exp_s.valid = live;
            exp_illegal = di.valid && !live;
            if (!live) begin
                exp_s.reg_write = 0; exp_s.mem_write = 0; exp_s.jump = 0; exp_s.branch = 0;
                exp_s.alu_src_a = 0; exp_s.alu_src_b = 0; exp_s.adder_src = 0;
                exp_s.res_src = '0; exp_s.alu_control = '0; exp_s.funct3 = '0;
            end
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        if (bubble && exp_cnt < CNT_MAX) exp_cnt++;
`endif
        #1;
        check_all(ctx);
    endtask

    // Assert reset a little after an edge, keep toggling inputs, then release on a falling edge.
    task automatic apply_reset(input int cycles);
        #2;
        rst_n = 1'b0;
        exp_s = '0;
        exp_illegal = 1'b0;
        exp_cnt = 0;
        #1;
        check_all("rst_async");
        for (int i = 0; i < cycles; i++) begin
            rand_inputs(30, 30);
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        #1;
    endtask

    initial begin
        slot_t saved;

        // Reset with random inputs, then the first add.
        apply_reset(3);
        di = '0;
        di.valid = 1; di.op = 7'b0110011; di.reg_write = 1; di.rd = 5; di.rd1 = 32'h10;
        tick("add");
        check("add.reg_write_e", 32'(reg_write_e), 32'd1);
        check("add.rd_e", 32'(rd_e), 32'd5);
        check("add.rd1_e", rd1_e, 32'h10);
        check("add.valid_e", 32'(valid_e), 32'd1);

        // Load a lw, then stall three cycles with changing inputs.
        di = '0;
        di.valid = 1; di.op = 7'b0000011; di.reg_write = 1; di.res_src = 2'b01;
        di.rd = 7; di.rs1 = 3; di.imm = 32'h24; di.pc = 32'h100; di.pc4 = 32'h104;
        tick("lw");
        saved = exp_s;
        for (int i = 0; i < 3; i++) begin
            rand_inputs(0, 100);
            flush = 0;
            stall = 1;
            tick("stall");
        end
        check("stall.pc_e", pc_e, 32'h100);
        check("stall.rd_e", 32'(rd_e), 32'(saved.rd));

        // Flush beats stall with a valid sw waiting.
        di = '0;
        di.valid = 1; di.op = 7'b0100011; di.mem_write = 1; di.funct3 = 3'b010;
        stall = 1; flush = 1;
        tick("flush_prio");
        check("flush_prio.valid_e", 32'(valid_e), 32'd0);
        check("flush_prio.mem_write_e", 32'(mem_write_e), 32'd0);
        stall = 0; flush = 0;

        // Illegal opcode: captured as a bubble with data kept.
        di = '0;
        di.valid = 1; di.op = 7'b1111111; di.reg_write = 1; di.pc = 32'hdead_beec;
        tick("illegal");
        check("illegal.illegal_e", 32'(illegal_e), 32'd1);
        check("illegal.reg_write_e", 32'(reg_write_e), 32'd0);
        check("illegal.pc_e", pc_e, 32'hdead_beec);

        // Empty slot with stray jump/branch.
        di = '0;
        di.valid = 0; di.op = 7'b1101111; di.jump = 1; di.branch = 1;
        tick("invalid");
        check("invalid.jump_e", 32'(jump_e), 32'd0);
        check("invalid.branch_e", 32'(branch_e), 32'd0);

        // Counter saturation: five flushes from a clean reset.
        apply_reset(1);
        for (int i = 0; i < 5; i++) begin
            rand_inputs(100, 0);
            flush = 1;
            tick("cnt_flush");
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        check("cnt.saturated", 32'(bubble_cnt), 32'(CNT_MAX));
`else
        check("cnt.tied_zero", 32'(bubble_cnt), 32'd0);
`endif

        // Reset in the middle of a stall: nothing survives.
        flush = 0;
        di = '0; di.valid = 1; di.op = 7'b1100011; di.branch = 1; di.rs1 = 9;
        tick("pre_stall");
        stall = 1;
        tick("mid_stall");
        apply_reset(2);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rand_inputs(10, 20);
            tick("rand");
            if ($urandom_range(0, 99) == 0) apply_reset(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
